exception_unit: RTL and testbench

EXCEPTION_UNIT -- requirements
Module: exception_unit

---
 rtl/exception_unit_pkg.sv | 50 +++++
 rtl/exception_unit_if.sv | 55 +++++
 rtl/exception_unit_int_sync.sv | 34 +++
 rtl/exception_unit.sv | 156 +++++++++++++++
 tb/tb_exception_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/exception_unit_pkg.sv
// -----------------------------------------------------------------------------
// exception_unit_pkg
// Shared definitions for the exception unit and CP0: exception codes, the
// exception vector, flag bit positions in flags_m, the redirect FSM state
// enum and a helper for data-access alignment.
// -----------------------------------------------------------------------------
package exception_unit_pkg;

    // Exception codes as written into Cause.ExcCode by CP0
    localparam logic [4:0] EXC_CODE_INT  = 5'h00;
    localparam logic [4:0] EXC_CODE_ADEL = 5'h04;
    localparam logic [4:0] EXC_CODE_ADES = 5'h05;
    localparam logic [4:0] EXC_CODE_SYS  = 5'h08;
    localparam logic [4:0] EXC_CODE_BP   = 5'h09;
    localparam logic [4:0] EXC_CODE_RI   = 5'h0A;
    localparam logic [4:0] EXC_CODE_OV   = 5'h0C;
    // Idle marker: no exception this cycle
    localparam logic [4:0] EXC_CODE_NONE = 5'h1F;

    // Common exception entry point (BEV=1 general vector)
    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    // Bit positions inside flags_m = {adel_fetch, ri, ov, sys, bp, eret}
    localparam int FLAG_ADEL_FETCH = 5;
    localparam int FLAG_RI         = 4;
    localparam int FLAG_OV         = 3;
    localparam int FLAG_SYS        = 2;
    localparam int FLAG_BP         = 1;
    localparam int FLAG_ERET       = 0;

    // Redirect handshake FSM
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } eu_state_t;

    // size: 0=byte, 1=half, 2=word. The unused encoding 3 is held to word
    // alignment so a malformed size can never slip through as aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                           input logic [1:0] size);
        logic mis;
        case (size)
            2'd0:    mis = 1'b0;
            2'd1:    mis = addr_lo[0];
            default: mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/exception_unit_if.sv
// -----------------------------------------------------------------------------
// exception_unit_if
// Bundles the MEM-stage inputs, CP0 values, interrupt lines and the
// CP0 / flush / fetch-redirect outputs of the exception unit.
//   slave  : exception unit side
//   master : pipeline / CP0 / fetch side
// -----------------------------------------------------------------------------
interface exception_unit_if;

    // MEM stage
    logic        mem_valid;
    logic        stall_m;
    logic [31:0] pc_m;
    logic        in_delayslot_m;
    logic [5:0]  flags_m;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [1:0]  mem_size;
    // Interrupts and CP0 state
    logic [5:0]  ext_int;
    logic [31:0] status_i;
    logic [31:0] cause_i;
    logic [31:0] epc_i;
    // To CP0
    logic [4:0]  except_type;
    logic        cp0_en;
    logic        is_eret;
    logic [31:0] badvaddr_o;
    logic [31:0] epc_pc;
    logic        epc_ds;
    logic [5:0]  ext_int_o;
    // Pipeline control / fetch redirect
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport slave (
        input  mem_valid, stall_m, pc_m, in_delayslot_m, flags_m,
               mem_ren, mem_wen, mem_addr, mem_size,
               ext_int, status_i, cause_i, epc_i, redirect_ready,
        output except_type, cp0_en, is_eret, badvaddr_o, epc_pc, epc_ds,
               ext_int_o, flush, redirect_valid, redirect_pc
    );

    modport master (
        output mem_valid, stall_m, pc_m, in_delayslot_m, flags_m,
               mem_ren, mem_wen, mem_addr, mem_size,
               ext_int, status_i, cause_i, epc_i, redirect_ready,
        input  except_type, cp0_en, is_eret, badvaddr_o, epc_pc, epc_ds,
               ext_int_o, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/exception_unit_int_sync.sv
// -----------------------------------------------------------------------------
// int_sync
// Two-flop synchronizer for the asynchronous hardware interrupt lines.
// Ports: clk, rst (sync, active high), d (raw lines), q (synchronized,
// two cycles later).
// -----------------------------------------------------------------------------
module int_sync #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_reg;
    logic [WIDTH-1:0] sync_reg;

    // Each line is independent; bits are never sampled as a coherent word.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        always_ff @(posedge clk) begin
            if (rst) begin
                meta_reg[gi] <= 1'b0;
                sync_reg[gi] <= 1'b0;
            end else begin
                meta_reg[gi] <= d[gi];
                sync_reg[gi] <= meta_reg[gi];
            end
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
// Resolves exceptions/interrupts for the instruction in MEM, reports the
// winning code to CP0, flushes the pipe and redirects fetch either to the
// exception vector or to EPC (eret). If fetch cannot take the redirect in
// the commit cycle, the target is latched and presented until accepted
// (HOLD), during which no further instruction may commit.
//
// Ports: clk, rst (sync, active high), eu (exception_unit_if.slave) carrying
// the MEM-stage inputs, CP0 values, ext_int, and the CP0/flush/redirect
// outputs.
//
// Build option: define INT_SYNC_EN to pass ext_int through a 2-flop
// synchronizer (ext_int_o lags by two cycles); otherwise ext_int_o = ext_int.
// -----------------------------------------------------------------------------
module exception_unit
    import exception_unit_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    exception_unit_if.slave eu
);

    eu_state_t   state_reg, state_next;
    logic [31:0] held_pc_reg, held_pc_next;

    logic [5:0]  ext_int_cond;
    logic [7:0]  ip_eff;
    logic        int_pend;
    logic        mis;
    logic        load_ade;
    logic        store_ade;
    logic        commit;
    logic        exc_hit;
    logic [4:0]  exc_code;
    logic [31:0] badv;
    logic [31:0] redir_pc;

    // Status/Cause bits this unit does not look at
    logic        unused_bits;
    assign unused_bits = ^{eu.status_i[31:16], eu.status_i[7:2],
                           eu.cause_i[31:16], eu.cause_i[7:0]};

`ifdef INT_SYNC_EN
    int_sync #(.WIDTH(6)) u_int_sync (
        .clk (clk),
        .rst (rst),
        .d   (eu.ext_int),
        .q   (ext_int_cond)
    );
`else
    assign ext_int_cond = eu.ext_int;
`endif

    assign eu.ext_int_o = ext_int_cond;
    assign eu.epc_pc    = eu.pc_m;
    assign eu.epc_ds    = eu.in_delayslot_m;

    // Hardware lines IP7..IP2 as CP0 will see them, plus software IP1..IP0
    assign ip_eff   = {eu.cause_i[15:10] | ext_int_cond, eu.cause_i[9:8]};
    assign int_pend = (|(eu.status_i[15:8] & ip_eff)) & eu.status_i[0] & ~eu.status_i[1];

    assign mis       = is_misaligned(eu.mem_addr[1:0], eu.mem_size);
    assign load_ade  = eu.mem_ren & mis;
    assign store_ade = eu.mem_wen & mis;

    assign commit = eu.mem_valid & ~eu.stall_m & (state_reg == ST_IDLE);

    // Priority resolution; badv follows the winning exception only.
    always_comb begin
        exc_hit  = 1'b1;
        exc_code = EXC_CODE_NONE;
        badv     = 32'h0;
        if (int_pend) begin
            exc_code = EXC_CODE_INT;
        end else if (eu.flags_m[FLAG_ADEL_FETCH]) begin
            exc_code = EXC_CODE_ADEL;
            badv     = eu.pc_m;
        end else if (eu.flags_m[FLAG_RI]) begin
            exc_code = EXC_CODE_RI;
        end else if (eu.flags_m[FLAG_OV]) begin
            exc_code = EXC_CODE_OV;
        end else if (eu.flags_m[FLAG_SYS]) begin
            exc_code = EXC_CODE_SYS;
        end else if (eu.flags_m[FLAG_BP]) begin
            exc_code = EXC_CODE_BP;
        end else if (load_ade) begin
            exc_code = EXC_CODE_ADEL;
            badv     = eu.mem_addr;
        end else if (store_ade) begin
            exc_code = EXC_CODE_ADES;
            badv     = eu.mem_addr;
        end else begin
            exc_hit  = 1'b0;
        end
    end

    assign eu.badvaddr_o = badv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            held_pc_reg <= 32'h0;
        end else begin
            state_reg   <= state_next;
            held_pc_reg <= held_pc_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        held_pc_next      = held_pc_reg;
        redir_pc          = 32'h0;
        eu.except_type    = EXC_CODE_NONE;
        eu.cp0_en         = 1'b0;
        eu.is_eret        = 1'b0;
        eu.flush          = 1'b0;
        eu.redirect_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (commit && (exc_hit || eu.flags_m[FLAG_ERET])) begin
                    eu.flush          = 1'b1;
                    eu.redirect_valid = 1'b1;
                    if (exc_hit) begin
                        eu.cp0_en      = 1'b1;
                        eu.except_type = exc_code;
                        redir_pc       = EXC_VECTOR;
                    end else begin
                        eu.is_eret     = 1'b1;
                        redir_pc       = eu.epc_i;
                    end
                    if (!eu.redirect_ready) begin
                        state_next   = ST_HOLD;
                        held_pc_next = redir_pc;
                    end
                end
            end
            ST_HOLD: begin
                // CP0 was already updated in the commit cycle; only the
                // flush and the redirect persist. stall_m is irrelevant here.
                eu.flush          = 1'b1;
                eu.redirect_valid = 1'b1;
                redir_pc          = held_pc_reg;
                if (eu.redirect_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign eu.redirect_pc = redir_pc;

endmodule

// File: tb/tb_exception_unit.sv
module tb_exception_unit;
    import exception_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    exception_unit_if bus();

    exception_unit dut (
        .clk (clk),
        .rst (rst),
        .eu  (bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    typedef struct {
        string       name;
        logic        mv;
        logic        st;
        logic [31:0] pc;
        logic        ds;
        logic [5:0]  fl;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  sz;
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] epc;
        logic [4:0]  e_type;
        logic        e_cp0;
        logic        e_eret;
        logic [31:0] e_badv;
        logic        e_flush;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic mv, logic st, logic [31:0] pc, logic ds,
                                logic [5:0] fl, logic ren, logic wen, logic [31:0] addr,
                                logic [1:0] sz, logic [31:0] status, logic [31:0] cause,
                                logic [31:0] epc, logic [4:0] e_type, logic e_cp0,
                                logic e_eret, logic [31:0] e_badv, logic e_flush,
                                logic e_rv, logic [31:0] e_rpc);
        vec_t v;
        v.name = name; v.mv = mv; v.st = st; v.pc = pc; v.ds = ds; v.fl = fl;
        v.ren = ren; v.wen = wen; v.addr = addr; v.sz = sz; v.status = status;
        v.cause = cause; v.epc = epc; v.e_type = e_type; v.e_cp0 = e_cp0;
        v.e_eret = e_eret; v.e_badv = e_badv; v.e_flush = e_flush; v.e_rv = e_rv;
        v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.mem_valid = 0; bus.stall_m = 0; bus.pc_m = 0; bus.in_delayslot_m = 0;
        bus.flags_m = 0; bus.mem_ren = 0; bus.mem_wen = 0; bus.mem_addr = 0;
        bus.mem_size = 0; bus.ext_int = 0; bus.status_i = 0; bus.cause_i = 0;
        bus.epc_i = 0; bus.redirect_ready = 1;
    endtask

    task automatic apply(input vec_t v);
        bus.mem_valid = v.mv; bus.stall_m = v.st; bus.pc_m = v.pc;
        bus.in_delayslot_m = v.ds; bus.flags_m = v.fl; bus.mem_ren = v.ren;
        bus.mem_wen = v.wen; bus.mem_addr = v.addr; bus.mem_size = v.sz;
        bus.status_i = v.status; bus.cause_i = v.cause; bus.epc_i = v.epc;
        bus.redirect_ready = 1;
    endtask

    initial begin
        // name mv st pc ds flags ren wen addr sz status cause epc | type cp0 eret badv flush rv rpc
        vecs.push_back(mk("idle",        0,0,32'h100,     0,6'b000000,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk("lw_adel",     1,0,32'h80000100,0,6'b000000,1,0,32'h1002,2'd2,32'h0,    32'h0,   32'h0,        5'h04,1,0,32'h1002,     1,1,VEC));
        vecs.push_back(mk("ri_ov",       1,0,32'h80000104,0,6'b011000,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h0A,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("int_ip7_sys", 1,0,32'h80000108,1,6'b000100,0,0,32'h0,   2'd0,32'hFF01, 32'h8000,32'h0,        5'h00,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("fetch_adel",  1,0,32'h80000003,0,6'b100000,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h04,1,0,32'h80000003, 1,1,VEC));
        vecs.push_back(mk("fetch_vs_ri", 1,0,32'h80000011,0,6'b110000,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h04,1,0,32'h80000011, 1,1,VEC));
        vecs.push_back(mk("ov",          1,0,32'h80000200,0,6'b001000,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h0C,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("sys",         1,0,32'h80000204,0,6'b000100,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h08,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("bp",          1,0,32'h80000208,0,6'b000010,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h09,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("sh_ades",     1,0,32'h8000020C,0,6'b000000,0,1,32'h2001,2'd1,32'h0,    32'h0,   32'h0,        5'h05,1,0,32'h2001,     1,1,VEC));
        vecs.push_back(mk("lh_aligned",  1,0,32'h80000210,0,6'b000000,1,0,32'h2002,2'd1,32'h0,    32'h0,   32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk("lb_any",      1,0,32'h80000214,0,6'b000000,1,0,32'h2003,2'd0,32'h0,    32'h0,   32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk("sw_aligned",  1,0,32'h80000218,0,6'b000000,0,1,32'h2004,2'd2,32'h0,    32'h0,   32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk("eret",        1,0,32'h8000021C,0,6'b000001,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h80001234, 5'h1F,0,1,32'h0,        1,1,32'h80001234));
        vecs.push_back(mk("eret_sys",    1,0,32'h80000220,0,6'b000101,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h80001234, 5'h08,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("sys_vs_ld",   1,0,32'h80000224,0,6'b000100,1,0,32'h1001,2'd2,32'h0,    32'h0,   32'h0,        5'h08,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("exl_masks",   1,0,32'h80000228,0,6'b000100,0,0,32'h0,   2'd0,32'hFF03, 32'h8000,32'h0,        5'h08,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("ie_off",      1,0,32'h8000022C,0,6'b000100,0,0,32'h0,   2'd0,32'hFF00, 32'h8000,32'h0,        5'h08,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("ip2_int",     1,0,32'h80000230,0,6'b000000,0,0,32'h0,   2'd0,32'h0401, 32'h0400,32'h0,        5'h00,1,0,32'h0,        1,1,VEC));
        vecs.push_back(mk("ip_masked",   1,0,32'h80000234,0,6'b000000,0,0,32'h0,   2'd0,32'h0401, 32'h0800,32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk("stall_bp",    1,1,32'h80000238,0,6'b000010,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));
        vecs.push_back(mk("novalid_bp",  0,0,32'h8000023C,0,6'b000010,0,0,32'h0,   2'd0,32'h0,    32'h0,   32'h0,        5'h1F,0,0,32'h0,        0,0,32'h0));

        // ---------------- reset ----------------
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_type",  {27'b0, bus.except_type}, 32'h1F);
        chk("rst_cp0",   {31'b0, bus.cp0_en}, 32'h0);
        chk("rst_flush", {31'b0, bus.flush}, 32'h0);
        chk("rst_rv",    {31'b0, bus.redirect_valid}, 32'h0);
        $display("txn reset: type=%h flush=%b rv=%b", bus.except_type, bus.flush, bus.redirect_valid);

        // ---------------- table vectors ----------------
        foreach (vecs[i]) begin
            @(posedge clk);
            #1 apply(vecs[i]);
            @(negedge clk);
            chk({vecs[i].name, ".type"},  {27'b0, bus.except_type}, {27'b0, vecs[i].e_type});
            chk({vecs[i].name, ".cp0"},   {31'b0, bus.cp0_en}, {31'b0, vecs[i].e_cp0});
            chk({vecs[i].name, ".eret"},  {31'b0, bus.is_eret}, {31'b0, vecs[i].e_eret});
            chk({vecs[i].name, ".badv"},  bus.badvaddr_o, vecs[i].e_badv);
            chk({vecs[i].name, ".flush"}, {31'b0, bus.flush}, {31'b0, vecs[i].e_flush});
            chk({vecs[i].name, ".rv"},    {31'b0, bus.redirect_valid}, {31'b0, vecs[i].e_rv});
            if (vecs[i].e_rv)
                chk({vecs[i].name, ".rpc"}, bus.redirect_pc, vecs[i].e_rpc);
            chk({vecs[i].name, ".epc_pc"}, bus.epc_pc, vecs[i].pc);
            chk({vecs[i].name, ".epc_ds"}, {31'b0, bus.epc_ds}, {31'b0, vecs[i].ds});
            $display("txn %s: type=%h cp0=%b eret=%b badv=%h flush=%b rv=%b rpc=%h",
                     vecs[i].name, bus.except_type, bus.cp0_en, bus.is_eret, bus.badvaddr_o,
                     bus.flush, bus.redirect_valid, bus.redirect_pc);
        end

        // ---------------- eret with stalled redirect -> HOLD ----------------
        @(posedge clk);
        #1 idle_inputs();
        bus.mem_valid = 1; bus.pc_m = 32'h80000300; bus.flags_m = 6'b000001;
        bus.epc_i = 32'h80001234; bus.redirect_ready = 0;
        @(negedge clk);
        chk("hold_commit_eret", {31'b0, bus.is_eret}, 32'h1);
        chk("hold_commit_rpc",  bus.redirect_pc, 32'h80001234);
        $display("txn eret_commit: eret=%b rv=%b rpc=%h", bus.is_eret, bus.redirect_valid, bus.redirect_pc);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 bus.flags_m = 6'b000100; bus.epc_i = 32'h0; bus.pc_m = 32'h90000000 + k;
            bus.stall_m = (k == 1);
            @(negedge clk);
            chk("hold_rv",    {31'b0, bus.redirect_valid}, 32'h1);
            chk("hold_rpc",   bus.redirect_pc, 32'h80001234);
            chk("hold_flush", {31'b0, bus.flush}, 32'h1);
            chk("hold_cp0",   {31'b0, bus.cp0_en}, 32'h0);
            chk("hold_type",  {27'b0, bus.except_type}, 32'h1F);
            chk("hold_eret",  {31'b0, bus.is_eret}, 32'h0);
            $display("txn hold%0d: rv=%b rpc=%h cp0=%b type=%h", k, bus.redirect_valid,
                     bus.redirect_pc, bus.cp0_en, bus.except_type);
        end
        @(posedge clk);
        #1 bus.redirect_ready = 1; bus.stall_m = 0;
        @(negedge clk);
        chk("hold_accept_rv",  {31'b0, bus.redirect_valid}, 32'h1);
        chk("hold_accept_rpc", bus.redirect_pc, 32'h80001234);
        chk("hold_accept_cp0", {31'b0, bus.cp0_en}, 32'h0);
        $display("txn hold_accept: rv=%b rpc=%h", bus.redirect_valid, bus.redirect_pc);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("after_hold_type", {27'b0, bus.except_type}, 32'h08);
        chk("after_hold_rpc",  bus.redirect_pc, VEC);
        $display("txn after_hold: type=%h rpc=%h", bus.except_type, bus.redirect_pc);

        // ---------------- stall then release ----------------
        @(posedge clk);
        #1 idle_inputs();
        bus.mem_valid = 1; bus.stall_m = 1; bus.flags_m = 6'b000010; bus.pc_m = 32'h80000400;
        @(negedge clk);
        chk("stall_cp0", {31'b0, bus.cp0_en}, 32'h0);
        chk("stall_rv",  {31'b0, bus.redirect_valid}, 32'h0);
        $display("txn stall_bp: cp0=%b type=%h", bus.cp0_en, bus.except_type);
        @(posedge clk);
        #1 bus.stall_m = 0;
        @(negedge clk);
        chk("unstall_type", {27'b0, bus.except_type}, 32'h09);
        chk("unstall_cp0",  {31'b0, bus.cp0_en}, 32'h1);
        $display("txn unstall_bp: cp0=%b type=%h", bus.cp0_en, bus.except_type);

        // ---------------- reset during HOLD ----------------
        @(posedge clk);
        #1 idle_inputs();
        bus.mem_valid = 1; bus.flags_m = 6'b000100; bus.redirect_ready = 0;
        @(negedge clk);
        chk("rsthold_commit_rv", {31'b0, bus.redirect_valid}, 32'h1);
        @(posedge clk);
        #1 rst = 1; bus.mem_valid = 0;
        @(negedge clk);
        chk("rsthold_pre_rv", {31'b0, bus.redirect_valid}, 32'h1);
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rsthold_rv",    {31'b0, bus.redirect_valid}, 32'h0);
        chk("rsthold_flush", {31'b0, bus.flush}, 32'h0);
        chk("rsthold_type",  {27'b0, bus.except_type}, 32'h1F);
        $display("txn rst_in_hold: rv=%b flush=%b", bus.redirect_valid, bus.flush);
        @(posedge clk);
        #1 bus.mem_valid = 1; bus.redirect_ready = 1;
        @(negedge clk);
        chk("rsthold_idle_type", {27'b0, bus.except_type}, 32'h08);
        @(posedge clk);
        #1 bus.mem_valid = 0;
        @(negedge clk);
        chk("rsthold_idle_rv", {31'b0, bus.redirect_valid}, 32'h0);
        $display("txn post_rst_commit: rv=%b", bus.redirect_valid);

        // ---------------- external interrupt path ----------------
        @(posedge clk);
        #1 idle_inputs();
        bus.ext_int = 6'h2A;
`ifdef INT_SYNC_EN
        @(negedge clk);
        chk("ext_int_lag", {26'b0, bus.ext_int_o}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
`endif
        @(negedge clk);
        chk("ext_int_o", {26'b0, bus.ext_int_o}, 32'h2A);
        @(posedge clk);
        #1 bus.mem_valid = 1; bus.status_i = 32'h8001; bus.pc_m = 32'h80000500;
        @(negedge clk);
        chk("ext_int_type", {27'b0, bus.except_type}, 32'h00);
        $display("txn ext_int: ext_int_o=%h type=%h", bus.ext_int_o, bus.except_type);

        @(posedge clk);
        #1 idle_inputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
